spi_slv: RTL and testbench

SPI_SLV -- requirements
Module: spi_slv

---
 rtl/spi_pkg.sv | 18 +
 rtl/spi_sync.sv | 22 ++
 rtl/spi_slv.sv | 132 +++++++++++++
 tb/tb_spi_slv.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// SPI slave shared definitions: default frame length, counter width helper
// and the frame state encoding (also used by the spi_drv master block).
package spi_pkg;

  localparam int SPI_MAXLEN_DEF = 32;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ACTIVE     = 2'd1,
    WAIT_DESEL = 2'd2
  } spi_state_t;

  // bit counter must hold 0..maxlen inclusive
  function automatic int cnt_w(input int maxlen);
    return $clog2(maxlen) + 1;
  endfunction

endpackage

// File: rtl/spi_sync.sv
// N-flop synchronizer with a parameterised reset value.
// Ports: clk, sresetn (async, active-low), d (async input), q (synced).
module spi_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic sresetn,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge sresetn) begin
    if (!sresetn) ff <= {STAGES{RST_VAL}};
    else          ff <= (ff << 1) | STAGES'(d);
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/spi_slv.sv
// SPI mode-0 slave: synchronized SCLK/SS_N/MOSI, MSB-first shift in/out.
// Ports: clk, sresetn, SPI pins, tx_load/tx_data/tx_rdy, rx_* result, busy.
module spi_slv
  import spi_pkg::*;
#(
  parameter int SPI_MAXLEN  = SPI_MAXLEN_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          sresetn,
  input  logic                          SCLK,
  input  logic                          SS_N,
  input  logic                          MOSI,
  output logic                          MISO,
  input  logic                          tx_load,
  input  logic [SPI_MAXLEN-1:0]         tx_data,
  output logic                          tx_rdy,
  output logic [SPI_MAXLEN-1:0]         rx_data,
  output logic [cnt_w(SPI_MAXLEN)-1:0]  rx_len,
  output logic                          rx_valid,
  output logic                          rx_ovf,
  output logic                          busy
);

  localparam int            CW   = cnt_w(SPI_MAXLEN);
  localparam logic [CW-1:0] MAXC = CW'(SPI_MAXLEN);

  logic sclk_s, ss_s, mosi_s;

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
    .clk(clk), .sresetn(sresetn), .d(SCLK), .q(sclk_s)
  );
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss (
    .clk(clk), .sresetn(sresetn), .d(SS_N), .q(ss_s)
  );
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
    .clk(clk), .sresetn(sresetn), .d(MOSI), .q(mosi_s)
  );

  logic                   sclk_q, ss_q;
  logic [SYNC_STAGES:0]   settle;
  spi_state_t             state_q, state_d;
  logic [SPI_MAXLEN-1:0]  tx_buf, tx_sr, rx_sr;
  logic [CW-1:0]          cnt;
  logic                   ovf;

  logic sclk_rise, sclk_fall, ss_fall, ss_rise;
  logic settled, start;

  assign sclk_rise = sclk_s & ~sclk_q;
  assign sclk_fall = ~sclk_s & sclk_q;
  assign ss_fall   = ~ss_s & ss_q;
  assign ss_rise   = ss_s & ~ss_q;
  // edges are meaningless until the synchronizers hold real pin values
  assign settled   = settle[SYNC_STAGES];
  assign start     = (state_q == IDLE) && (state_d == ACTIVE);

  always_ff @(posedge clk or negedge sresetn) begin
    if (!sresetn) begin
      sclk_q  <= 1'b0;
      ss_q    <= 1'b1;
      settle  <= '0;
      state_q <= IDLE;
    end else begin
      sclk_q  <= sclk_s;
      ss_q    <= ss_s;
      settle  <= {settle[SYNC_STAGES-1:0], 1'b1};
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (settled) begin
          if (ss_fall)    state_d = ACTIVE;
          // select already low out of reset: skip that frame
          else if (!ss_s) state_d = WAIT_DESEL;
        end
      end
      ACTIVE:     if (ss_rise) state_d = IDLE;
      WAIT_DESEL: if (ss_s)    state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge sresetn) begin
    if (!sresetn) begin
      tx_buf   <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      cnt      <= '0;
      ovf      <= 1'b0;
      rx_data  <= '0;
      rx_len   <= '0;
      rx_ovf   <= 1'b0;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      // a load colliding with frame start keeps the old word
      if (tx_load && !busy && !start) tx_buf <= tx_data;
      if (start) begin
        tx_sr <= tx_buf;
        rx_sr <= '0;
        cnt   <= '0;
        ovf   <= 1'b0;
      end else if (state_q == ACTIVE) begin
        if (sclk_rise) begin
          if (cnt == MAXC) begin
            ovf <= 1'b1;
          end else begin
            rx_sr <= {rx_sr[SPI_MAXLEN-2:0], mosi_s};
            cnt   <= cnt + 1'b1;
          end
        end
        if (sclk_fall) tx_sr <= {tx_sr[SPI_MAXLEN-2:0], 1'b0};
        if (ss_rise) begin
          rx_data  <= rx_sr;
          rx_len   <= cnt;
          rx_ovf   <= ovf;
          rx_valid <= 1'b1;
        end
      end
    end
  end

  assign busy   = (state_q != IDLE);
  assign tx_rdy = ~busy;
  assign MISO   = (state_q == ACTIVE) & tx_sr[SPI_MAXLEN-1];

endmodule

// File: tb/tb_spi_slv.sv
// Directed bench for spi_slv: bit-banged mode-0 master plus a frame-level
// model of what each side must receive.
module tb_spi_slv;
  import spi_pkg::*;

  localparam int ML = 32;
  localparam int LW = cnt_w(ML);

  logic          clk = 1'b0;
  logic          sresetn, SCLK, SS_N, MOSI, MISO;
  logic          tx_load, tx_rdy, rx_valid, rx_ovf, busy;
  logic [ML-1:0] tx_data, rx_data;
  logic [LW-1:0] rx_len;

  always #5 clk = ~clk;

  spi_slv #(.SPI_MAXLEN(ML), .SYNC_STAGES(2)) dut (
    .clk(clk), .sresetn(sresetn),
    .SCLK(SCLK), .SS_N(SS_N), .MOSI(MOSI), .MISO(MISO),
    .tx_load(tx_load), .tx_data(tx_data), .tx_rdy(tx_rdy),
    .rx_data(rx_data), .rx_len(rx_len),
    .rx_valid(rx_valid), .rx_ovf(rx_ovf), .busy(busy)
  );

  typedef struct packed {
    logic [31:0]   d;
    logic [LW-1:0] l;
    logic          o;
  } exp_t;

  exp_t          expq[$];
  int            total = 0;
  int            bad = 0;
  logic [31:0]   mbuf;
  logic [31:0]   last_d;
  logic [LW-1:0] last_l;
  logic          last_o;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // master view of slave word: first n bits MSB-first, then zeros
  function automatic logic [63:0] mexp(input logic [31:0] b, input int n);
    logic [63:0] w;
    w = {b, 32'h0};
    return (n == 0) ? 64'h0 : (w >> (64 - n));
  endfunction

  // one clock plus the per-cycle output checks
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (!sresetn) begin
      chk("rst_rx_valid", rx_valid, 0);
      chk("rst_rx_data", rx_data, 0);
      chk("rst_rx_len", rx_len, 0);
      chk("rst_rx_ovf", rx_ovf, 0);
      chk("rst_busy", busy, 0);
      chk("rst_miso", MISO, 0);
      last_d = '0;
      last_l = '0;
      last_o = 1'b0;
    end else begin
      chk("tx_rdy", tx_rdy, !busy);
      if (!busy) chk("miso_idle", MISO, 0);
      if (rx_valid) begin
        if (expq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_rx_valid: got 1 want 0");
        end else begin
          e = expq.pop_front();
          chk("rx_data", rx_data, e.d);
          chk("rx_len", rx_len, e.l);
          chk("rx_ovf", rx_ovf, e.o);
        end
        last_d = rx_data;
        last_l = rx_len;
        last_o = rx_ovf;
      end else begin
        chk("hold_data", rx_data, last_d);
        chk("hold_len", rx_len, last_l);
        chk("hold_ovf", rx_ovf, last_o);
      end
    end
  endtask

  task automatic load(input logic [31:0] v);
    tx_data = v;
    tx_load = 1'b1;
    tick();
    tx_load = 1'b0;
    mbuf = v;
  endtask

  // n bits of mtx (LSB-aligned) MSB first; rst_at>=0 resets after that bit
  task automatic spi_frame(input int n, input logic [63:0] mtx,
                           input int rst_at, input bit hold_load,
                           output logic [63:0] mrx);
    exp_t e;
    int   k;
    mrx = '0;
    if (rst_at < 0) begin
      k   = (n > 32) ? 32 : n;
      e.d = 32'((mtx >> (n - k)) & ((64'd1 << k) - 64'd1));
      e.l = LW'(k);
      e.o = (n > 32);
      expq.push_back(e);
    end
    SS_N = 1'b0;
    repeat (6) tick();
    if (hold_load) begin
      tx_data = '1;
      tx_load = 1'b1;
    end
    repeat (2) tick();
    for (int i = 0; i < n; i++) begin
      MOSI = mtx[n-1-i];
      repeat (4) tick();
      SCLK = 1'b1;
      mrx  = {mrx[62:0], MISO};
      if (rst_at >= 0 && i > rst_at) chk("wd_miso", MISO, 0);
      chk("busy_bit", busy, 1);
      chk("rdy_bit", tx_rdy, 0);
      repeat (8) tick();
      SCLK = 1'b0;
      repeat (4) tick();
      if (i == rst_at) begin
        sresetn = 1'b0;
        repeat (3) tick();
        sresetn = 1'b1;
        mbuf = '0;
        repeat (5) tick();
        chk("wd_busy", busy, 1);
      end
    end
    repeat (12) tick();
    tx_load = 1'b0;
    SS_N = 1'b1;
    for (int t = 0; t < 20 && expq.size() != 0; t++) tick();
    if (expq.size() != 0) begin
      total++;
      bad++;
      $display("FAIL rx_valid_timeout: got none want %0d", expq.size());
      expq.delete();
    end
    repeat (4) tick();
    chk("busy_after", busy, 0);
  endtask

  initial begin
    logic [63:0] mrx;
    sresetn = 1'b0;
    SCLK    = 1'b0;
    SS_N    = 1'b1;
    MOSI    = 1'b0;
    tx_load = 1'b0;
    tx_data = '0;
    mbuf    = '0;
    last_d  = '0;
    last_l  = '0;
    last_o  = 1'b0;
    repeat (3) tick();
    sresetn = 1'b1;
    repeat (6) tick();
    chk("init_busy", busy, 0);
    chk("init_rx_len", rx_len, 0);

    // 8-bit loopback; 0x3C response left-aligned in the word
    load(32'h3C00_0000);
    spi_frame(8, 64'hA5, -1, 1'b0, mrx);
    chk("lb_mrx", mrx, mexp(mbuf, 8));
    chk("lb_lit_mrx", mrx, 64'h3C);
    chk("lb_lit_data", rx_data, 32'h0000_00A5);
    chk("lb_lit_len", rx_len, 8);
    chk("lb_lit_ovf", rx_ovf, 0);

    // full 32-bit exchange
    load(32'h1234_5678);
    spi_frame(32, 64'hDEAD_BEEF, -1, 1'b0, mrx);
    chk("f32_mrx", mrx, mexp(mbuf, 32));
    chk("f32_lit_mrx", mrx, 64'h1234_5678);
    chk("f32_lit_data", rx_data, 32'hDEAD_BEEF);
    chk("f32_lit_len", rx_len, 32);

    // 40 pulses: overflow, buffer reused without reload
    spi_frame(40, 64'hDE_ADBE_EF99, -1, 1'b0, mrx);
    chk("ovf_mrx", mrx, mexp(mbuf, 40));
    chk("ovf_lit_mrx", mrx, 64'h12_3456_7800);
    chk("ovf_lit_data", rx_data, 32'hDEAD_BEEF);
    chk("ovf_lit_len", rx_len, 32);
    chk("ovf_lit_ovf", rx_ovf, 1);

    // select with no clocks
    spi_frame(0, 64'h0, -1, 1'b0, mrx);
    chk("zero_lit_len", rx_len, 0);
    chk("zero_lit_data", rx_data, 0);
    chk("zero_lit_ovf", rx_ovf, 0);

    // tx_load of all-ones while busy is ignored
    load(32'h5A00_0000);
    spi_frame(8, 64'h0F, -1, 1'b1, mrx);
    chk("busyld_mrx", mrx, mexp(mbuf, 8));
    chk("busyld_lit_mrx", mrx, 64'h5A);
    spi_frame(8, 64'hC3, -1, 1'b0, mrx);
    chk("busyld2_lit_mrx", mrx, 64'h5A);
    chk("busyld2_lit_data", rx_data, 32'hC3);

    // reset after bit 5, then a clean frame with a cleared buffer
    spi_frame(8, 64'h96, 4, 1'b0, mrx);
    spi_frame(8, 64'h3B, -1, 1'b0, mrx);
    chk("postrst_mrx", mrx, mexp(mbuf, 8));
    chk("postrst_lit_mrx", mrx, 64'h0);
    chk("postrst_lit_data", rx_data, 32'h3B);
    chk("postrst_lit_len", rx_len, 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
